// File: rtl/test_rr_arbiter.sv
// test_rr_arbiter: round-robin arbiter sharing one test output bit between N_REQ requesters
module test_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    input  logic [N_REQ-1:0]         data_in,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout,
    output logic                     data_out
);
    localparam int W = $clog2(N_REQ);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state_q, state_d;
    logic [W-1:0] ptr_q, ptr_d, id_q, id_d, pick;
    logic [W:0] sum;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [7:0] hold_q, hold_d;
    logic timeout_q, timeout_d, found, forced, rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // scan from the highest offset down so the nearest request after ptr wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_q} + (W + 1)'(i);
            sum = sum >= (W + 1)'(N_REQ) ? sum - (W + 1)'(N_REQ) : sum;
            if (req[sum[W-1:0]]) begin
                pick  = sum[W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        forced    = hold_q == 8'(MAX_HOLD);
        rel       = done[id_q] | ~req[id_q] | forced;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                id_d    = pick;
                grant_d = N_REQ'(1) << pick;
                hold_d  = 8'd1;
            end
        end else if (rel) begin
            state_d   = IDLE;
            grant_d   = '0;
            ptr_d     = id_q == W'(N_REQ - 1) ? '0 : id_q + 1'b1;
            timeout_d = forced & ~done[id_q] & req[id_q];
        end else begin
            hold_d = hold_q == 8'hff ? hold_q : hold_q + 8'd1;
        end
    end

    always_comb begin
        busy     = state_q == GRANT;
        grant    = grant_q;
        grant_id = id_q;
        timeout  = timeout_q;
        data_out = busy & data_in[id_q];
    end
endmodule

// File: tb/tb_test_rr_arbiter.sv
// tb_test_rr_arbiter: directed and random stimulus checked against a cycle-level reference model
module tb_test_rr_arbiter;
    localparam int N = 4;
    localparam int MAX = 8;
    logic clk = 1'b0, rst;
    logic [N-1:0] req, done, data_in, grant;
    logic [1:0] grant_id;
    logic busy, timeout, data_out;
    int n_chk = 0, n_fail = 0;
    int m_busy, m_owner, m_ptr, m_hold, m_to;

    always #5 clk = ~clk;

    test_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done), .data_in(data_in),
        .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout), .data_out(data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] dn, input logic [N-1:0] di);
        bit d, w, m;
        rst = r; req = rq; done = dn; data_in = di;
        @(posedge clk);
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 0;
        end else if (m_busy == 0) begin
            m_to = 0;
            for (int i = 0; i < N; i++)
                if (m_busy == 0 && rq[(m_ptr + i) % N]) begin
                    m_busy = 1; m_owner = (m_ptr + i) % N; m_hold = 1;
                end
        end else begin
            d = dn[m_owner]; w = !rq[m_owner]; m = m_hold == MAX;
            if (d || w || m) begin
                m_busy = 0; m_ptr = (m_owner + 1) % N; m_to = m && !d && !w;
            end else begin
                m_hold = m_hold < 255 ? m_hold + 1 : m_hold; m_to = 0;
            end
        end
        #1;
        chk("grant", grant, m_busy != 0 ? 32'(1) << m_owner : 0);
        chk("busy", busy, m_busy);
        chk("timeout", timeout, m_to);
        chk("data_out", data_out, m_busy != 0 ? di[m_owner] : 1'b0);
        if (m_busy != 0) chk("grant_id", grant_id, m_owner);
    endtask

    initial begin
        logic [N-1:0] rq, dn;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 4'b0100, 0, 0);
        step(0, 4'b0100, 4'b0100, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 4'b1111, grant, 4'b1010);
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 4'b0001, 0, 4'b0001);
        step(0, 4'b0010, 0, 4'b0010);
        step(0, 4'b0010, 0, 4'b0010);
        step(0, 4'b0010, 0, 4'b1000);
        step(0, 4'b0010, 0, 4'b0000);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4 && grant != 4'b1000; i++) step(0, 4'b1000, 0, 0);
        step(1, 4'b1000, 0, 0);
        step(0, 4'b1001, 0, 0);
        step(1, 0, 0, 0);
        step(0, 4'b0001, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 4'b0001, 4'b1000, 0);
        step(0, 4'b0001, 4'b1001, 0);
        step(0, 0, 0, 0);
        rq = 4'b1111;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) rq = N'($urandom);
            dn = N'($urandom & $urandom & $urandom & $urandom);
            step($urandom_range(63) == 0, rq, dn, N'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
